ram_arbiter: RTL and testbench

- Shares the single synchronous data-RAM port between two requesters: m0 (CPU load/store path) and m1 (debug/loader or DMA path).
- Arbitrates at most one access per cycle, round-robin by default, with optional bus lock.
- Drives the registered RAM command interface and steers returning read data to the requester that issued the read.
- Sits between the CPU core and the RAM macro, at the top level.

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_arb_rd_pipe.sv | 68 ++++++
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCK0    = 2'd1,
      LOCK1    = 2'd2
   } arb_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int MAX_RD_LATENCY = 4;

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Valid/owner-tag delay line for RAM reads; produces the per-requester read
// data strobes and holds the captured read data between strobes.
module ram_arb_rd_pipe
   import ram_arb_pkg::*;
#(
   parameter int g_RAM_WIDTH  = 11,
   parameter int g_RD_LATENCY = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic                   i_tag,
   input  logic [g_RAM_WIDTH-1:0] i_ram_data,
   output logic                   o_m0_rvalid,
   output logic [g_RAM_WIDTH-1:0] o_m0_rdata,
   output logic                   o_m1_rvalid,
   output logic [g_RAM_WIDTH-1:0] o_m1_rdata
);

   // Out-of-range latencies are clamped so the delay line is always legal.
   localparam int LAT   = (g_RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY :
                          ((g_RD_LATENCY < 1) ? 1 : g_RD_LATENCY);
   localparam int DEPTH = LAT + 1;

   logic [DEPTH-1:0]       valid_reg;
   logic [DEPTH-1:0]       tag_reg;
   logic                   m0_rvalid_reg;
   logic                   m1_rvalid_reg;
   logic [g_RAM_WIDTH-1:0] m0_rdata_reg;
   logic [g_RAM_WIDTH-1:0] m1_rdata_reg;
   logic                   last_valid;
   logic                   last_tag;

   assign last_valid = valid_reg[DEPTH-1];
   assign last_tag   = tag_reg[DEPTH-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_reg <= '0;
         tag_reg   <= '0;
      end else begin
         valid_reg <= {valid_reg[DEPTH-2:0], i_push};
         tag_reg   <= {tag_reg[DEPTH-2:0], i_tag};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m0_rvalid_reg <= 1'b0;
         m1_rvalid_reg <= 1'b0;
         m0_rdata_reg  <= '0;
         m1_rdata_reg  <= '0;
      end else begin
         m0_rvalid_reg <= last_valid && (last_tag == M0);
         m1_rvalid_reg <= last_valid && (last_tag == M1);
         if (last_valid && (last_tag == M0))
            m0_rdata_reg <= i_ram_data;
         if (last_valid && (last_tag == M1))
            m1_rdata_reg <= i_ram_data;
      end
   end

   assign o_m0_rvalid = m0_rvalid_reg;
   assign o_m0_rdata  = m0_rdata_reg;
   assign o_m1_rvalid = m1_rvalid_reg;
   assign o_m1_rdata  = m1_rdata_reg;

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single synchronous RAM port with bus lock.
// Define RAM_ARB_FIXED_PRIO_EN to make m0 win every unlocked conflict.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int g_RAM_WIDTH  = 11,
   parameter int g_RAM_ADDR   = 9,
   parameter int g_RD_LATENCY = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_m0_req,
   input  logic                   i_m0_we,
   input  logic                   i_m0_lock,
   input  logic [g_RAM_ADDR-1:0]  i_m0_addr,
   input  logic [g_RAM_WIDTH-1:0] i_m0_data,
   output logic                   o_m0_gnt,
   output logic                   o_m0_rvalid,
   output logic [g_RAM_WIDTH-1:0] o_m0_rdata,
   input  logic                   i_m1_req,
   input  logic                   i_m1_we,
   input  logic                   i_m1_lock,
   input  logic [g_RAM_ADDR-1:0]  i_m1_addr,
   input  logic [g_RAM_WIDTH-1:0] i_m1_data,
   output logic                   o_m1_gnt,
   output logic                   o_m1_rvalid,
   output logic [g_RAM_WIDTH-1:0] o_m1_rdata,
   output logic                   o_ram_en,
   output logic                   o_ram_we,
   output logic                   o_ram_re,
   output logic [g_RAM_ADDR-1:0]  o_ram_addr,
   output logic [g_RAM_WIDTH-1:0] o_ram_data,
   input  logic [g_RAM_WIDTH-1:0] i_ram_data
);

   arb_state_t             state_reg;
   arb_state_t             state_next;
   logic                   lock0_held;
   logic                   lock1_held;
   logic                   gnt0;
   logic                   gnt1;
   logic                   accept;
   logic                   sel_we;
   logic [g_RAM_ADDR-1:0]  sel_addr;
   logic [g_RAM_WIDTH-1:0] sel_data;
   logic                   ram_en_reg;
   logic                   ram_we_reg;
   logic                   ram_re_reg;
   logic [g_RAM_ADDR-1:0]  ram_addr_reg;
   logic [g_RAM_WIDTH-1:0] ram_data_reg;
`ifndef RAM_ARB_FIXED_PRIO_EN
   logic                   r_last_reg;
`endif

   // An owner that is idle with lock low releases the bus in the same cycle.
   assign lock0_held = (state_reg == LOCK0) && (i_m0_req || i_m0_lock);
   assign lock1_held = (state_reg == LOCK1) && (i_m1_req || i_m1_lock);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (lock0_held) begin
         gnt0 = i_m0_req;
      end else if (lock1_held) begin
         gnt1 = i_m1_req;
      end else if (i_m0_req && i_m1_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         gnt0 = 1'b1;
`else
         if (r_last_reg == M1)
            gnt0 = 1'b1;
         else
            gnt1 = 1'b1;
`endif
      end else begin
         gnt0 = i_m0_req;
         gnt1 = i_m1_req;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (lock0_held)
         state_next = (gnt0 && !i_m0_lock) ? UNLOCKED : LOCK0;
      else if (lock1_held)
         state_next = (gnt1 && !i_m1_lock) ? UNLOCKED : LOCK1;
      else if (gnt0 && i_m0_lock)
         state_next = LOCK0;
      else if (gnt1 && i_m1_lock)
         state_next = LOCK1;
      else
         state_next = UNLOCKED;
   end

   assign accept   = gnt0 || gnt1;
   assign sel_we   = gnt1 ? i_m1_we   : i_m0_we;
   assign sel_addr = gnt1 ? i_m1_addr : i_m0_addr;
   assign sel_data = gnt1 ? i_m1_data : i_m0_data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg    <= UNLOCKED;
         ram_en_reg   <= 1'b0;
         ram_we_reg   <= 1'b0;
         ram_re_reg   <= 1'b0;
         ram_addr_reg <= '0;
         ram_data_reg <= '0;
      end else begin
         state_reg  <= state_next;
         ram_en_reg <= accept;
         ram_we_reg <= accept && sel_we;
         ram_re_reg <= accept && !sel_we;
         if (accept) begin
            ram_addr_reg <= sel_addr;
            ram_data_reg <= sel_data;
         end
      end
   end

`ifndef RAM_ARB_FIXED_PRIO_EN
   // Starts at M1 so that m0 wins the first conflict after reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_last_reg <= M1;
      else if (accept)
         r_last_reg <= gnt1;
   end
`endif

   ram_arb_rd_pipe #(
      .g_RAM_WIDTH  (g_RAM_WIDTH),
      .g_RD_LATENCY (g_RD_LATENCY)
   ) u_rd_pipe (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (accept && !sel_we),
      .i_tag       (gnt1),
      .i_ram_data  (i_ram_data),
      .o_m0_rvalid (o_m0_rvalid),
      .o_m0_rdata  (o_m0_rdata),
      .o_m1_rvalid (o_m1_rvalid),
      .o_m1_rdata  (o_m1_rdata)
   );

   assign o_m0_gnt   = gnt0;
   assign o_m1_gnt   = gnt1;
   assign o_ram_en   = ram_en_reg;
   assign o_ram_we   = ram_we_reg;
   assign o_ram_re   = ram_re_reg;
   assign o_ram_addr = ram_addr_reg;
   assign o_ram_data = ram_data_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a one-cycle-latency synchronous RAM model.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m0_lock;
   logic [8:0]  m0_addr;
   logic [10:0] m0_data;
   logic        m0_gnt, m0_rvalid;
   logic [10:0] m0_rdata;
   logic        m1_req, m1_we, m1_lock;
   logic [8:0]  m1_addr;
   logic [10:0] m1_data;
   logic        m1_gnt, m1_rvalid;
   logic [10:0] m1_rdata;
   logic        ram_en, ram_we, ram_re;
   logic [8:0]  ram_addr;
   logic [10:0] ram_wdata;
   logic [10:0] ram_q;

   logic        pl_we;
   logic [8:0]  pl_addr;
   logic [10:0] pl_data;
   logic [10:0] mem [0:511];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_m0_req    (m0_req),
      .i_m0_we     (m0_we),
      .i_m0_lock   (m0_lock),
      .i_m0_addr   (m0_addr),
      .i_m0_data   (m0_data),
      .o_m0_gnt    (m0_gnt),
      .o_m0_rvalid (m0_rvalid),
      .o_m0_rdata  (m0_rdata),
      .i_m1_req    (m1_req),
      .i_m1_we     (m1_we),
      .i_m1_lock   (m1_lock),
      .i_m1_addr   (m1_addr),
      .i_m1_data   (m1_data),
      .o_m1_gnt    (m1_gnt),
      .o_m1_rvalid (m1_rvalid),
      .o_m1_rdata  (m1_rdata),
      .o_ram_en    (ram_en),
      .o_ram_we    (ram_we),
      .o_ram_re    (ram_re),
      .o_ram_addr  (ram_addr),
      .o_ram_data  (ram_wdata),
      .i_ram_data  (ram_q)
   );

   always @(posedge clk) begin
      if (pl_we)
         mem[pl_addr] <= pl_data;
      if (ram_en && ram_we)
         mem[ram_addr] <= ram_wdata;
      if (ram_en && ram_re)
         ram_q <= mem[ram_addr];
   end

   always @(negedge clk) begin
      if (m0_gnt) $display("txn m0 we=%0b addr=%h data=%h", m0_we, m0_addr, m0_data);
      if (m1_gnt) $display("txn m1 we=%0b addr=%h data=%h", m1_we, m1_addr, m1_data);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [8:0] a, input logic [10:0] d);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      step();
      pl_we = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(); step();
      n_cmp++; if (ram_en !== 1'b0) begin n_err++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
      n_cmp++; if (ram_we !== 1'b0 || ram_re !== 1'b0) begin n_err++; $display("FAIL rst_ram_we_re: got %b%b want 00", ram_we, ram_re); end
      n_cmp++; if (ram_addr !== 9'h000) begin n_err++; $display("FAIL rst_ram_addr: got %h want 000", ram_addr); end
      n_cmp++; if (ram_wdata !== 11'h000) begin n_err++; $display("FAIL rst_ram_data: got %h want 000", ram_wdata); end
      n_cmp++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid); end
      n_cmp++; if (m0_rdata !== 11'h000 || m1_rdata !== 11'h000) begin n_err++; $display("FAIL rst_rdata: got %h %h want 000 000", m0_rdata, m1_rdata); end
      n_cmp++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt_noreq: got %b%b want 00", m0_gnt, m1_gnt); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_read;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h012;
      #1;
      n_cmp++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_err++; $display("FAIL sr_gnt: got %b%b want 10", m0_gnt, m1_gnt); end
      step();
      m0_req = 1'b0;
      n_cmp++; if (ram_en !== 1'b1 || ram_re !== 1'b1 || ram_we !== 1'b0) begin n_err++; $display("FAIL sr_cmd: en/re/we got %b%b%b want 110", ram_en, ram_re, ram_we); end
      n_cmp++; if (ram_addr !== 9'h012) begin n_err++; $display("FAIL sr_addr: got %h want 012", ram_addr); end
      step();
      n_cmp++; if (m0_rvalid !== 1'b0 || ram_en !== 1'b0) begin n_err++; $display("FAIL sr_t2: rvalid/en got %b%b want 00", m0_rvalid, ram_en); end
      step();
      n_cmp++; if (m0_rvalid !== 1'b1 || m0_rdata !== 11'h5A5) begin n_err++; $display("FAIL sr_rvalid: got %b %h want 1 5a5", m0_rvalid, m0_rdata); end
      n_cmp++; if (m1_rvalid !== 1'b0 || m1_rdata !== 11'h000) begin n_err++; $display("FAIL sr_m1_quiet: got %b %h want 0 000", m1_rvalid, m1_rdata); end
      step();
      n_cmp++; if (m0_rvalid !== 1'b0 || m0_rdata !== 11'h5A5) begin n_err++; $display("FAIL sr_hold: got %b %h want 0 5a5", m0_rvalid, m0_rdata); end
   endtask

   task automatic test_round_robin;
      logic own [0:3];
      logic exp_o;
      rst = 1'b1; step(); rst = 1'b0; step();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h012;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h001;
      for (int k = 0; k < 7; k++) begin
         if (k >= 1 && k <= 4) begin
            n_cmp++; if (ram_en !== 1'b1 || ram_addr !== (own[k-1] ? 9'h001 : 9'h012)) begin n_err++; $display("FAIL rr_busy%0d: en/addr got %b %h", k, ram_en, ram_addr); end
         end
         if (k >= 3) begin
            exp_o = own[k-3];
            n_cmp++; if (m0_rvalid !== !exp_o || m1_rvalid !== exp_o) begin n_err++; $display("FAIL rr_rvalid%0d: got %b%b want %b%b", k, m0_rvalid, m1_rvalid, !exp_o, exp_o); end
            n_cmp++; if ((exp_o ? m1_rdata : m0_rdata) !== (exp_o ? 11'h111 : 11'h5A5)) begin n_err++; $display("FAIL rr_rdata%0d: got %h %h", k, m0_rdata, m1_rdata); end
         end
         if (k == 4) begin m0_req = 1'b0; m1_req = 1'b0; end
         if (k < 4) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            own[k] = 1'b0;
`else
            own[k] = (k % 2) == 1;
`endif
            #1;
            n_cmp++; if (m0_gnt !== !own[k] || m1_gnt !== own[k]) begin n_err++; $display("FAIL rr_gnt%0d: got %b%b want %b%b", k, m0_gnt, m1_gnt, !own[k], own[k]); end
         end
         step();
      end
   endtask

   task automatic test_lock;
      m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1; m1_addr = 9'h100; m1_data = 11'h7FF;
      #1;
      n_cmp++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_err++; $display("FAIL lk_gnt1: got %b%b want 01", m0_gnt, m1_gnt); end
      step();
      n_cmp++; if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_re !== 1'b0) begin n_err++; $display("FAIL lk_wcmd: en/we/re got %b%b%b want 110", ram_en, ram_we, ram_re); end
      n_cmp++; if (ram_addr !== 9'h100 || ram_wdata !== 11'h7FF) begin n_err++; $display("FAIL lk_waddr: got %h %h want 100 7ff", ram_addr, ram_wdata); end
      m1_req = 1'b0; m1_we = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h012;
      for (int k = 1; k < 4; k++) begin
         #1;
         n_cmp++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_err++; $display("FAIL lk_wait%0d: got %b%b want 00", k, m0_gnt, m1_gnt); end
         step();
         if (k < 3) begin
            n_cmp++; if (ram_en !== 1'b0) begin n_err++; $display("FAIL lk_idle%0d: en got %b want 0", k, ram_en); end
         end
      end
      m1_lock = 1'b0;
      #1;
      n_cmp++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_err++; $display("FAIL lk_release: got %b%b want 10", m0_gnt, m1_gnt); end
      step();
      m0_req = 1'b0;
      n_cmp++; if (ram_re !== 1'b1 || ram_addr !== 9'h012) begin n_err++; $display("FAIL lk_rcmd: re/addr got %b %h want 1 012", ram_re, ram_addr); end
      step(); step();
      n_cmp++; if (m0_rvalid !== 1'b1 || m0_rdata !== 11'h5A5) begin n_err++; $display("FAIL lk_rvalid: got %b %h want 1 5a5", m0_rvalid, m0_rdata); end
      step();
   endtask

   task automatic test_back_to_back;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h001;
      #1;
      n_cmp++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL bb_gnt_a: got %b want 1", m0_gnt); end
      step();
      m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h002;
      #1;
      n_cmp++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_err++; $display("FAIL bb_gnt_b: got %b%b want 01", m0_gnt, m1_gnt); end
      step();
      m1_req = 1'b0; m0_req = 1'b1; m0_addr = 9'h003;
      #1;
      n_cmp++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL bb_gnt_c: got %b want 1", m0_gnt); end
      step();
      m0_req = 1'b0;
      n_cmp++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 11'h111) begin n_err++; $display("FAIL bb_ret_a: got %b%b %h want 10 111", m0_rvalid, m1_rvalid, m0_rdata); end
      step();
      n_cmp++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 11'h222) begin n_err++; $display("FAIL bb_ret_b: got %b%b %h want 01 222", m0_rvalid, m1_rvalid, m1_rdata); end
      n_cmp++; if (m0_rdata !== 11'h111) begin n_err++; $display("FAIL bb_hold: got %h want 111", m0_rdata); end
      step();
      n_cmp++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 11'h333) begin n_err++; $display("FAIL bb_ret_c: got %b%b %h want 10 333", m0_rvalid, m1_rvalid, m0_rdata); end
      step();
   endtask

   task automatic test_reset_mid;
      logic exp1;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h001;
      #1;
      n_cmp++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL rm_gnt: got %b want 1", m0_gnt); end
      step();
      m0_req = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++; if (ram_en !== 1'b0 || ram_re !== 1'b0 || ram_addr !== 9'h000) begin n_err++; $display("FAIL rm_cmd_clr: got %b%b %h want 00 000", ram_en, ram_re, ram_addr); end
      n_cmp++; if (m0_rdata !== 11'h000 || m1_rdata !== 11'h000) begin n_err++; $display("FAIL rm_rdata_clr: got %h %h want 000 000", m0_rdata, m1_rdata); end
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         n_cmp++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_err++; $display("FAIL rm_no_rvalid%0d: got %b%b want 00", k, m0_rvalid, m1_rvalid); end
      end
      m0_req = 1'b1; m0_addr = 9'h012;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h001;
      #1;
      n_cmp++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_err++; $display("FAIL rm_first: got %b%b want 10", m0_gnt, m1_gnt); end
      step();
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp1 = 1'b0;
`else
      exp1 = 1'b1;
`endif
      #1;
      n_cmp++; if (m1_gnt !== exp1 || m0_gnt !== !exp1) begin n_err++; $display("FAIL rm_second: got %b%b want %b%b", m0_gnt, m1_gnt, !exp1, exp1); end
      step();
      m0_req = 1'b0;
      #1;
      n_cmp++; if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL rm_m1_alone: got %b want 1", m1_gnt); end
      step();
      m1_req = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      rst = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_data = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_data = '0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0;
      test_reset();
      preload(9'h012, 11'h5A5);
      preload(9'h001, 11'h111);
      preload(9'h002, 11'h222);
      preload(9'h003, 11'h333);
      step();
      test_single_read();
      test_round_robin();
      test_lock();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
